// File: rtl/dmem_mmio_responder.sv
// Data-memory responder: on-chip RAM below 0xFF0, console FIFO / cycle counter / one-shot timer above.
// Read data is registered (1 cycle). Console writes never stall: a push to a full FIFO is dropped and flags ovf.

module dmem_mmio_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_push_dat,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_head_dat,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_full,
    output logic                   o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;

    // Caller only pushes when space exists or a pop frees a slot, and only pops when non-empty.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (i_push && !i_pop)      r_count <= r_count + 1'b1;
            else if (!i_push && i_pop) r_count <= r_count - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (i_push) r_mem[r_wr_ptr] <= i_push_dat;
    end

    assign o_count    = r_count;
    assign o_empty    = (r_count == '0);
    assign o_full     = (r_count == (AW+1)'(DEPTH));
    assign o_head_dat = o_empty ? '0 : r_mem[r_rd_ptr];
endmodule

module dmem_mmio_responder #(
    parameter int    FIFO_DEPTH = 8,
    parameter string RAM_INIT   = ""
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [11:0] address_dmem,
    input  logic [31:0] data,
    input  logic        wren,
    output logic [31:0] q_dmem,
    output logic [31:0] tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        timer_irq
);
    localparam int          RAM_WORDS = 'hFF0;
    localparam int          CW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [11:0] A_CONSOLE = 12'hFF0;
    localparam logic [11:0] A_STATUS  = 12'hFF1;
    localparam logic [11:0] A_CYCLE   = 12'hFF2;
    localparam logic [11:0] A_TIMER   = 12'hFF3;
    localparam logic [11:0] A_TFLAG   = 12'hFF4;

    logic [31:0]   r_ram [RAM_WORDS];
    logic [31:0]   r_ram_q;
    logic          r_q_sel_ram;
    logic [31:0]   r_q_mmio;
    logic [31:0]   r_cycle;
    logic [31:0]   r_timer;
    logic          r_tflag;
    logic          r_ovf;

    logic          w_is_ram;
    logic          w_wr_console;
    logic          w_wr_status;
    logic          w_wr_cycle;
    logic          w_wr_timer;
    logic          w_wr_tflag;
    logic          w_pop;
    logic          w_push;
    logic          w_ovf_set;
    logic          w_tflag_set;
    logic          w_fifo_empty;
    logic          w_fifo_full;
    logic [CW-1:0] w_fifo_count;
    logic [31:0]   w_fifo_head;
    logic [31:0]   w_status;
    logic [31:0]   w_mmio_rd;

    assign w_is_ram     = (address_dmem < 12'hFF0);
    assign w_wr_console = wren && (address_dmem == A_CONSOLE);
    assign w_wr_status  = wren && (address_dmem == A_STATUS);
    assign w_wr_cycle   = wren && (address_dmem == A_CYCLE);
    assign w_wr_timer   = wren && (address_dmem == A_TIMER);
    assign w_wr_tflag   = wren && (address_dmem == A_TFLAG);

    // A pop in the same cycle frees the slot, so a push to a full FIFO still lands.
    assign w_pop     = !w_fifo_empty && tx_ready;
    assign w_push    = w_wr_console && (!w_fifo_full || w_pop);
    assign w_ovf_set = w_wr_console && w_fifo_full && !w_pop;

    // A coinciding load replaces the expiring count, so no expiry is reported.
    assign w_tflag_set = (r_timer == 32'd1) && !w_wr_timer;

    dmem_mmio_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_console_fifo (
        .clock      (clock),
        .reset      (reset),
        .i_push     (w_push),
        .i_push_dat (data),
        .i_pop      (w_pop),
        .o_head_dat (w_fifo_head),
        .o_count    (w_fifo_count),
        .o_full     (w_fifo_full),
        .o_empty    (w_fifo_empty)
    );

    assign w_status = {23'd0, 5'(w_fifo_count), 1'b0, r_ovf, w_fifo_full, w_fifo_empty};

    always_comb begin
        w_mmio_rd = '0;
        case (address_dmem)
            A_CONSOLE: w_mmio_rd = w_fifo_head;
            A_STATUS:  w_mmio_rd = w_status;
            A_CYCLE:   w_mmio_rd = r_cycle;
            A_TIMER:   w_mmio_rd = r_timer;
            A_TFLAG:   w_mmio_rd = {31'd0, r_tflag};
            default:   w_mmio_rd = '0;
        endcase
    end

    // RAM sits outside the reset domain so its contents survive reset.
    always_ff @(posedge clock) begin
        if (w_is_ram) begin
            if (wren) r_ram[address_dmem] <= data;
            r_ram_q <= r_ram[address_dmem];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cycle     <= '0;
            r_timer     <= '0;
            r_tflag     <= 1'b0;
            r_ovf       <= 1'b0;
            r_q_sel_ram <= 1'b0;
            r_q_mmio    <= '0;
        end else begin
            r_cycle <= w_wr_cycle ? data : r_cycle + 32'd1;

            if (w_wr_timer)           r_timer <= data;
            else if (r_timer != '0)   r_timer <= r_timer - 32'd1;

            if (w_tflag_set)                r_tflag <= 1'b1;
            else if (w_wr_tflag && data[0]) r_tflag <= 1'b0;

            if (w_ovf_set)                  r_ovf <= 1'b1;
            else if (w_wr_status && data[2]) r_ovf <= 1'b0;

            r_q_sel_ram <= w_is_ram;
            r_q_mmio    <= w_mmio_rd;
        end
    end

    assign q_dmem    = r_q_sel_ram ? r_ram_q : r_q_mmio;
    assign tx_data   = w_fifo_head;
    assign tx_valid  = !w_fifo_empty;
    assign timer_irq = r_tflag;
endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Directed bench for dmem_mmio_responder: read responses go through an expected-value queue
// checked by a monitor one cycle after each read; side outputs are checked directly.

module tb_dmem_mmio_responder;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [11:0] address_dmem = '0;
    logic [31:0] data = '0;
    logic        wren = 1'b0;
    logic [31:0] q_dmem;
    logic [31:0] tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic        timer_irq;

    always #5 clock = ~clock;

    dmem_mmio_responder #(
        .FIFO_DEPTH (8),
        .RAM_INIT   ("")
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .address_dmem (address_dmem),
        .data         (data),
        .wren         (wren),
        .q_dmem       (q_dmem),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .timer_irq    (timer_irq)
    );

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [31:0] exp_q[$];
    string       name_q[$];
    logic        rd_issue = 1'b0;
    logic        rd_pend  = 1'b0;
    logic [31:0] mon_exp;
    string       mon_name;
    logic [31:0] drain_exp [8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    always @(posedge clock) rd_pend <= rd_issue;

    always @(negedge clock) begin
        if (rd_pend) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL scoreboard_underflow: got a read response, expected none pending");
            end else begin
                mon_exp  = exp_q.pop_front();
                mon_name = name_q.pop_front();
                chk(mon_name, q_dmem, mon_exp);
            end
        end
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        address_dmem = a;
        data         = d;
        wren         = 1'b1;
        rd_issue     = 1'b0;
        cyc();
        wren         = 1'b0;
    endtask

    task automatic rd(input logic [11:0] a, input logic [31:0] exp, input string nm);
        address_dmem = a;
        wren         = 1'b0;
        rd_issue     = 1'b1;
        exp_q.push_back(exp);
        name_q.push_back(nm);
        cyc();
        rd_issue     = 1'b0;
    endtask

    task automatic rdwr(input logic [11:0] a, input logic [31:0] d, input logic [31:0] exp, input string nm);
        address_dmem = a;
        data         = d;
        wren         = 1'b1;
        rd_issue     = 1'b1;
        exp_q.push_back(exp);
        name_q.push_back(nm);
        cyc();
        wren         = 1'b0;
        rd_issue     = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no end of test, expected finish before 100us");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #2 reset = 1'b0;
        #1;
        chk("reset_q_dmem", q_dmem, 32'h0);
        chk("reset_tx_valid", {31'd0, tx_valid}, 32'h0);
        chk("reset_tx_data", tx_data, 32'h0);
        chk("reset_timer_irq", {31'd0, timer_irq}, 32'h0);
        repeat (2) cyc();
        reset = 1'b1;

        wr(12'hFF8, 32'h1234_5678);
        rd(12'hFF8, 32'h0, "reserved_rd");
        rd(12'hFF1, 32'h001, "status_reset");
        rd(12'hFF4, 32'h0, "tflag_reset");

        wr(12'h123, 32'hDEAD_BEEF);
        rd(12'h123, 32'hDEAD_BEEF, "ram_rd");
        rdwr(12'h123, 32'h1, 32'hDEAD_BEEF, "ram_rd_during_wr");
        rd(12'h123, 32'h1, "ram_rd_new");

        for (int i = 0; i < 9; i++) begin
            wr(12'hFF0, 32'h100 + i);
            if (i == 0) begin
                chk("first_push_tx_valid", {31'd0, tx_valid}, 32'h1);
                chk("first_push_tx_data", tx_data, 32'h100);
            end
        end
        rd(12'hFF1, 32'h086, "status_full_ovf");
        rd(12'hFF0, 32'h100, "console_head_rd");
        chk("full_tx_data", tx_data, 32'h100);
        wr(12'hFF1, 32'h4);
        rd(12'hFF1, 32'h082, "status_ovf_cleared");

        tx_ready = 1'b1;
        wr(12'hFF0, 32'h200);
        tx_ready = 1'b0;
        rd(12'hFF1, 32'h082, "status_push_pop_full");

        for (int i = 0; i < 8; i++) drain_exp[i] = (i < 7) ? 32'h101 + i : 32'h200;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("drain_valid_%0d", i), {31'd0, tx_valid}, 32'h1);
            chk($sformatf("drain_data_%0d", i), tx_data, drain_exp[i]);
            tx_ready = 1'b1;
            cyc();
        end
        tx_ready = 1'b0;
        chk("drained_tx_valid", {31'd0, tx_valid}, 32'h0);
        rd(12'hFF1, 32'h001, "status_drained");

        wr(12'hFF3, 32'd3);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("timer3_wait_%0d", k), {31'd0, timer_irq}, 32'h0);
            cyc();
        end
        chk("timer3_expire", {31'd0, timer_irq}, 32'h1);
        rd(12'hFF4, 32'h1, "tflag_rd_set");
        wr(12'hFF4, 32'h1);
        chk("tflag_clear", {31'd0, timer_irq}, 32'h0);

        wr(12'hFF3, 32'd0);
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk($sformatf("timer0_noflag_%0d", k), {31'd0, timer_irq}, 32'h0);
        end

        wr(12'hFF3, 32'd2);
        cyc();
        wr(12'hFF3, 32'd5);
        chk("reload_noflag", {31'd0, timer_irq}, 32'h0);
        for (int k = 1; k <= 5; k++) begin
            cyc();
            chk($sformatf("reload_wait_%0d", k), {31'd0, timer_irq}, (k == 5) ? 32'h1 : 32'h0);
        end

        wr(12'hFF4, 32'h1);
        chk("tflag_clear2", {31'd0, timer_irq}, 32'h0);
        wr(12'hFF3, 32'd2);
        cyc();
        wr(12'hFF4, 32'h1);
        chk("clear_vs_set", {31'd0, timer_irq}, 32'h1);

        wr(12'hFF2, 32'hFFFF_FFFE);
        cyc();
        rd(12'hFF2, 32'hFFFF_FFFF, "cycle_pre_wrap");
        rd(12'hFF2, 32'h0000_0000, "cycle_wrap");

        for (int i = 0; i < 3; i++) wr(12'hFF0, 32'h300 + i);
        wr(12'hFF3, 32'd100);
        address_dmem = 12'hFF0;
        cyc();
        chk("pre_reset_q_dmem", q_dmem, 32'h300);
        chk("pre_reset_tx_valid", {31'd0, tx_valid}, 32'h1);
        chk("pre_reset_irq", {31'd0, timer_irq}, 32'h1);
        #2 reset = 1'b0;
        #1;
        chk("async_q_dmem", q_dmem, 32'h0);
        chk("async_tx_valid", {31'd0, tx_valid}, 32'h0);
        chk("async_tx_data", tx_data, 32'h0);
        chk("async_timer_irq", {31'd0, timer_irq}, 32'h0);
        cyc();
        reset = 1'b1;
        rd(12'hFF2, 32'h0, "cycle_first_edge");
        rd(12'hFF2, 32'h1, "cycle_second_edge");
        rd(12'h123, 32'h1, "ram_after_reset");
        rd(12'hFF1, 32'h001, "status_after_reset");
        rd(12'hFF4, 32'h0, "tflag_after_reset");
        rd(12'hFF3, 32'h0, "timer_after_reset");

        repeat (2) cyc();
        chk("scoreboard_drain", 32'(exp_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
